// File: rtl/fb_scanout_if.sv
// Scan-out bundle: framebuffer read port, video output and control/status.
// The scan-out engine drives through 'master'; a framebuffer/encoder environment uses 'slave'.
interface fb_scanout_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8
);
  logic                  en;
  logic                  fb_en_rd;
  logic [ADDR_WIDTH-1:0] fb_addr_rd;
  logic [DATA_WIDTH-1:0] fb_dout;
  logic [DATA_WIDTH-1:0] pixel;
  logic                  de;
  logic                  hsync;
  logic                  vsync;
  logic                  frame_start;
  logic                  busy;

  modport master (
    input  en, fb_dout,
    output fb_en_rd, fb_addr_rd, pixel, de, hsync, vsync, frame_start, busy
  );

  modport slave (
    output en, fb_dout,
    input  fb_en_rd, fb_addr_rd, pixel, de, hsync, vsync, frame_start, busy
  );
endinterface

// File: rtl/fb_scanout.sv
// VGA raster generator reading the framebuffer once per active pixel with SxS replication;
// a 2-stage pipeline lines up read data with de/hsync/vsync/frame_start.
module fb_scanout #(
  parameter int FRAME_WIDTH    = 640,
  parameter int FRAME_HEIGHT   = 480,
  parameter int SCALING_FACTOR = 1,
  parameter int ADDR_WIDTH     = 19,
  parameter int DATA_WIDTH     = 8,
  parameter int H_FP           = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BP           = 48,
  parameter int V_FP           = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BP           = 33,
  parameter bit SYNC_POL       = 1'b0
) (
  input  logic         clk_rd,
  input  logic         rst_n,
  fb_scanout_if.master bus
);

  localparam int H_TOTAL = FRAME_WIDTH + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = FRAME_HEIGHT + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int COLS    = FRAME_WIDTH / SCALING_FACTOR;
  localparam int ROWS    = FRAME_HEIGHT / SCALING_FACTOR;
  localparam int SUB_W   = (SCALING_FACTOR > 1) ? $clog2(SCALING_FACTOR) : 1;

  localparam logic [HW-1:0] H_ACT  = HW'(FRAME_WIDTH);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_BEG = HW'(FRAME_WIDTH + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(FRAME_WIDTH + H_FP + H_SYNC - 1);

  localparam logic [VW-1:0] V_ACT      = VW'(FRAME_HEIGHT);
  localparam logic [VW-1:0] V_LAST_ACT = VW'(FRAME_HEIGHT - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_BEG     = VW'(FRAME_HEIGHT + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(FRAME_HEIGHT + V_FP + V_SYNC - 1);

  localparam logic [SUB_W-1:0]      SUB_LAST = SUB_W'(SCALING_FACTOR - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(COLS);

  if ((FRAME_WIDTH % SCALING_FACTOR) != 0 || (FRAME_HEIGHT % SCALING_FACTOR) != 0) begin : g_bad_scale
    $error("fb_scanout: frame size must be a multiple of SCALING_FACTOR");
  end

  if ((longint'(1) << ADDR_WIDTH) < longint'(COLS) * longint'(ROWS)) begin : g_bad_addr
    $error("fb_scanout: ADDR_WIDTH too small for the scaled framebuffer");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  r_state;
  logic [HW-1:0]           r_h_cnt;
  logic [VW-1:0]           r_v_cnt;
  logic [SUB_W-1:0]        r_x_sub;
  logic [SUB_W-1:0]        r_y_sub;
  logic [ADDR_WIDTH-1:0]   r_row_base;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_fb_en;

  logic                    r_act1;
  logic                    r_hs1;
  logic                    r_vs1;
  logic                    r_fs1;
  logic                    r_run1;

  logic [DATA_WIDTH-1:0]   r_pixel;
  logic                    r_de;
  logic                    r_hsync;
  logic                    r_vsync;
  logic                    r_frame_start;
  logic                    r_busy;

  logic                    w_h_last;
  logic                    w_v_last;
  logic                    w_frame_end;
  logic                    w_start;
  logic                    w_run_nxt;
  logic [HW-1:0]           w_h_nxt;
  logic [VW-1:0]           w_v_nxt;
  logic                    w_act_nxt;

  // Next raster position; a frame start (from IDLE or back-to-back) always lands on (0,0).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_h_nxt     = '0;
    w_v_nxt     = '0;
    w_h_last    = (r_h_cnt == H_LAST);
    w_v_last    = (r_v_cnt == V_LAST);
    w_frame_end = (r_state == RUN) && w_h_last && w_v_last;
    w_start     = bus.en && ((r_state == IDLE) || w_frame_end);
    w_run_nxt   = w_start || ((r_state == RUN) && !w_frame_end);
    if (w_run_nxt && !w_start) begin
      if (w_h_last) begin
        w_v_nxt = r_v_cnt + 1'b1;
      end else begin
        w_h_nxt = r_h_cnt + 1'b1;
        w_v_nxt = r_v_cnt;
      end
    end
    w_act_nxt = w_run_nxt && (w_h_nxt < H_ACT) && (w_v_nxt < V_ACT);
  end

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_rd) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_x_sub       <= '0;
      r_y_sub       <= '0;
      r_row_base    <= '0;
      r_addr        <= '0;
      r_fb_en       <= 1'b0;
      r_act1        <= 1'b0;
      r_hs1         <= 1'b0;
      r_vs1         <= 1'b0;
      r_fs1         <= 1'b0;
      r_run1        <= 1'b0;
      r_pixel       <= '0;
      r_de          <= 1'b0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      // Stage 0: counters plus read address/enable for the new position.
      r_state <= w_run_nxt ? RUN : IDLE;
      r_h_cnt <= w_h_nxt;
      r_v_cnt <= w_v_nxt;
      r_fb_en <= w_act_nxt;

      if (!w_run_nxt || w_start) begin
        r_x_sub    <= '0;
        r_y_sub    <= '0;
        r_row_base <= '0;
        r_addr     <= '0;
      end else if (w_h_last) begin
        r_x_sub <= '0;
        // Only reload when another active line follows, keeping row_base inside the buffer.
        if (r_v_cnt < V_LAST_ACT) begin
          if (r_y_sub == SUB_LAST) begin
            r_y_sub    <= '0;
            r_row_base <= r_row_base + ROW_STEP;
            r_addr     <= r_row_base + ROW_STEP;
          end else begin
            r_y_sub <= r_y_sub + 1'b1;
            r_addr  <= r_row_base;
          end
        end
      end else if (w_act_nxt) begin
        if (r_x_sub == SUB_LAST) begin
          r_x_sub <= '0;
          r_addr  <= r_addr + 1'b1;
        end else begin
          r_x_sub <= r_x_sub + 1'b1;
        end
      end

      // Stage 1: timing flags wait one clock while the framebuffer returns data.
      r_act1 <= r_fb_en;
      r_hs1  <= (r_state == RUN) && (r_h_cnt >= HS_BEG) && (r_h_cnt <= HS_END);
      r_vs1  <= (r_state == RUN) && (r_v_cnt >= VS_BEG) && (r_v_cnt <= VS_END);
      r_fs1  <= (r_state == RUN) && (r_h_cnt == '0) && (r_v_cnt == '0);
      r_run1 <= (r_state == RUN);

      // Stage 2: everything for one position leaves together.
      r_pixel       <= r_act1 ? bus.fb_dout : '0;
      r_de          <= r_act1;
      r_hsync       <= r_hs1 ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= r_vs1 ? SYNC_POL : ~SYNC_POL;
      r_frame_start <= r_fs1;
      r_busy        <= w_run_nxt || (r_state == RUN) || r_run1;
    end
  end

  assign bus.fb_en_rd    = r_fb_en;
  assign bus.fb_addr_rd  = r_addr;
  assign bus.pixel       = r_pixel;
  assign bus.de          = r_de;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.frame_start = r_frame_start;
  assign bus.busy        = r_busy;

endmodule
